// File: rtl/avmm_modport_slave.sv
// -----------------------------------------------------------------------------
// avmm_modport_slave
//
// Avalon-MM slave endpoint backed by a byte-enabled word memory. It accepts
// single and burst writes and reads, stalls the master with waitrequest, and
// returns read beats on readdata/readdatavalid.
//
// Ports
//   clk            in   clock, all logic on the rising edge
//   rst_n          in   asynchronous active-low reset
//   address        in   byte address of the first beat (low byte-offset bits
//                       and bits above the memory depth are ignored)
//   burstcount     in   beats in the transfer, 0 is treated as 1
//   writedata      in   write data for each beat
//   byteenable     in   per-byte write enable
//   write          in   write request
//   read           in   read request (a write presented in the same cycle wins)
//   waitrequest    out  stall; a beat is accepted when request=1 and waitrequest=0
//   readdata       out  read data, holds its last value between beats
//   readdatavalid  out  readdata is valid this cycle
// -----------------------------------------------------------------------------
module avmm_modport_slave #(
   parameter int ADDR_WIDTH        = 32,
   parameter int DATA_WIDTH        = 64,
   parameter int BURST_COUNT_WIDTH = 8,
   parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
   parameter int MEM_WORDS_LOG2    = 10,
   parameter int WAIT_STATES       = 0,
   parameter int READ_LATENCY      = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ADDR_WIDTH-1:0]        address,
   input  logic [BURST_COUNT_WIDTH-1:0] burstcount,
   input  logic [DATA_WIDTH-1:0]        writedata,
   input  logic [BYTE_ENABLE_WIDTH-1:0] byteenable,
   input  logic                         write,
   input  logic                         read,
   output logic                         waitrequest,
   output logic [DATA_WIDTH-1:0]        readdata,
   output logic                         readdatavalid
);

   localparam int   OFF_W     = $clog2(BYTE_ENABLE_WIDTH);
   localparam int   WCNT_W    = $clog2(WAIT_STATES + 2);
   localparam int   LAT_W     = $clog2(READ_LATENCY + 1);
   localparam int   LAT_INIT  = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;
   // waitrequest level while idle: low when every request can be taken at once
   localparam logic IDLE_WAIT = (WAIT_STATES != 0);

   typedef logic [MEM_WORDS_LOG2-1:0]    idx_t;
   typedef logic [BURST_COUNT_WIDTH-1:0] cnt_t;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WBURST, S_RPEND} state_t;

   state_t                  state_q, state_d;
   logic                    wait_q, wait_d;
   logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
   idx_t                    idx_q, idx_d;      // next word of the active burst
   cnt_t                    left_q, left_d;    // beats still to transfer
   logic [LAT_W-1:0]        lat_q, lat_d;      // RPEND cycles before streaming
   logic                    rdv_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic [DATA_WIDTH-1:0]   mem_q [2**MEM_WORDS_LOG2];

   idx_t                    req_idx;
   cnt_t                    req_cnt;
   logic                    can_accept, acc_wr, acc_rd;
   logic                    mem_we;
   idx_t                    mem_widx;
   logic                    emit;
   idx_t                    emit_idx;
   logic                    unused_addr;

   assign req_idx     = address[OFF_W +: MEM_WORDS_LOG2];
   assign req_cnt     = (burstcount == '0) ? cnt_t'(1) : burstcount;
   assign unused_addr = ^address;

   // New commands are only taken from IDLE/WAIT once waitrequest is low.
   assign can_accept = !wait_q && (state_q == S_IDLE || state_q == S_WAIT);
   assign acc_wr     = can_accept && write;
   assign acc_rd     = can_accept && read && !write;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d  = state_q;
      wait_d   = wait_q;
      wcnt_d   = wcnt_q;
      idx_d    = idx_q;
      left_d   = left_q;
      lat_d    = lat_q;
      mem_we   = 1'b0;
      mem_widx = req_idx;
      emit     = 1'b0;
      emit_idx = idx_q;

      unique case (state_q)
         S_IDLE, S_WAIT: begin
            if (acc_wr) begin
               mem_we = 1'b1;
               if (req_cnt > cnt_t'(1)) begin
                  // Burst beats follow back to back with no further stalls.
                  state_d = S_WBURST;
                  idx_d   = req_idx + idx_t'(1);
                  left_d  = req_cnt - cnt_t'(1);
                  wait_d  = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  wait_d  = IDLE_WAIT;
               end
            end else if (acc_rd) begin
               lat_d = LAT_W'(LAT_INIT);
               if (READ_LATENCY == 1) begin
                  // First beat leaves on the accept edge itself.
                  emit     = 1'b1;
                  emit_idx = req_idx;
                  idx_d    = req_idx + idx_t'(1);
                  left_d   = req_cnt - cnt_t'(1);
                  if (req_cnt == cnt_t'(1)) begin
                     state_d = S_IDLE;
                     wait_d  = IDLE_WAIT;
                  end else begin
                     state_d = S_RPEND;
                     wait_d  = 1'b1;
                  end
               end else begin
                  state_d = S_RPEND;
                  wait_d  = 1'b1;
                  idx_d   = req_idx;
                  left_d  = req_cnt;
               end
            end else if (state_q == S_IDLE) begin
               if ((write || read) && WAIT_STATES != 0) begin
                  // The IDLE cycle that sees the request is the first stall.
                  state_d = S_WAIT;
                  wcnt_d  = WCNT_W'(1);
                  wait_d  = (WAIT_STATES > 1);
               end else begin
                  wait_d = IDLE_WAIT;
               end
            end else if (wait_q) begin
               wcnt_d = wcnt_q + WCNT_W'(1);
               if (wcnt_d >= WCNT_W'(WAIT_STATES)) wait_d = 1'b0;
            end
         end

         S_WBURST: begin
            if (write) begin
               mem_we   = 1'b1;
               mem_widx = idx_q;
               idx_d    = idx_q + idx_t'(1);
               left_d   = left_q - cnt_t'(1);
               if (left_q == cnt_t'(1)) begin
                  state_d = S_IDLE;
                  wait_d  = IDLE_WAIT;
               end
            end
         end

         S_RPEND: begin
            if (lat_q != '0) begin
               lat_d = lat_q - LAT_W'(1);
            end else begin
               emit   = 1'b1;
               idx_d  = idx_q + idx_t'(1);
               left_d = left_q - cnt_t'(1);
               if (left_q == cnt_t'(1)) begin
                  state_d = S_IDLE;
                  wait_d  = IDLE_WAIT;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wait_q  <= 1'b1;
         wcnt_q  <= '0;
         idx_q   <= '0;
         left_q  <= '0;
         lat_q   <= '0;
         rdv_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge regardless of statement order.
         state_q <= state_d;
         wait_q  <= wait_d;
         wcnt_q  <= wcnt_d;
         idx_q   <= idx_d;
         left_q  <= left_d;
         lat_q   <= lat_d;
         rdv_q   <= emit;
         if (emit) rdata_q <= mem_q[emit_idx];
      end
   end

   // NOTE: the storage array has no reset; contents survive rst_n and only the
   // control path above is cleared.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < BYTE_ENABLE_WIDTH; b++) begin
            if (byteenable[b]) mem_q[mem_widx][b*8 +: 8] <= writedata[b*8 +: 8];
         end
      end
   end

   assign waitrequest   = wait_q;
   assign readdata      = rdata_q;
   assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_avmm_modport_slave.sv
// -----------------------------------------------------------------------------
// tb_avmm_modport_slave
//
// Drives two slaves: index 0 uses the default timing (no wait states, read
// latency 2); index 1 uses WAIT_STATES=3, READ_LATENCY=1. Reads push their
// expected beats (data and due cycle) from a word-array model into a
// per-slave queue; a monitor pops and compares on every readdatavalid.
// -----------------------------------------------------------------------------
module tb_avmm_modport_slave;

   localparam int RL0 = 2;
   localparam int RL1 = 1;
   localparam int WS1 = 3;

   typedef struct {
      logic [63:0] data;
      longint      cyc;
      bit          last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr_s  [2];
   logic [7:0]  bc_s    [2];
   logic [63:0] wdata_s [2];
   logic [7:0]  be_s    [2];
   logic        wr_s    [2];
   logic        rd_s    [2];
   logic        wait_s  [2];
   logic [63:0] rdata_s [2];
   logic        rdv_s   [2];

   exp_t        sb0 [$];
   exp_t        sb1 [$];
   logic [63:0] ref_mem [2][1024];
   logic [63:0] beat [256];
   int          n_vec  = 0;
   int          n_fail = 0;
   longint      cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   avmm_modport_slave dut0 (
      .clk(clk), .rst_n(rst_n), .address(addr_s[0]), .burstcount(bc_s[0]),
      .writedata(wdata_s[0]), .byteenable(be_s[0]), .write(wr_s[0]), .read(rd_s[0]),
      .waitrequest(wait_s[0]), .readdata(rdata_s[0]), .readdatavalid(rdv_s[0])
   );

   avmm_modport_slave #(.WAIT_STATES(WS1), .READ_LATENCY(RL1)) dut1 (
      .clk(clk), .rst_n(rst_n), .address(addr_s[1]), .burstcount(bc_s[1]),
      .writedata(wdata_s[1]), .byteenable(be_s[1]), .write(wr_s[1]), .read(rd_s[1]),
      .waitrequest(wait_s[1]), .readdata(rdata_s[1]), .readdatavalid(rdv_s[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name, input string what);
      n_vec++;
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   function automatic int rl(input int d);
      return (d == 0) ? RL0 : RL1;
   endfunction

   // Request must already be driven (at posedge+1). Returns at posedge+1 after
   // the accepting edge; stalls counts cycles seen with waitrequest high.
   task automatic handshake(input int d, output bit ok, output longint acc_cyc, output int stalls);
      ok = 1'b0;
      acc_cyc = 0;
      stalls = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (!wait_s[d]) begin
            ok = 1'b1;
            acc_cyc = cyc;
            break;
         end
         stalls++;
      end
      if (!ok) fail_event("accept_timeout", $sformatf("dut%0d never dropped waitrequest", d));
      @(posedge clk);
      #1;
   endtask

   // Burst/single write of beat[0..n-1]; optional one-cycle write=0 gap after beat 0.
   task automatic av_write(input int d, input logic [31:0] a, input logic [7:0] bc,
                           input logic [7:0] be, input bit gap, output int first_stalls);
      int     n;
      int     w;
      int     st;
      bit     ok;
      longint acc;
      n = (bc == 0) ? 1 : int'(bc);
      w = int'((a >> 3) & 32'd1023);
      first_stalls = 0;
      for (int i = 0; i < n; i++) begin
         addr_s[d]  = (i == 0) ? a : $urandom;
         bc_s[d]    = (i == 0) ? bc : 8'($urandom);
         wdata_s[d] = beat[i];
         be_s[d]    = be;
         wr_s[d]    = 1'b1;
         handshake(d, ok, acc, st);
         if (!ok) break;
         if (i == 0) first_stalls = st;
         else check($sformatf("burst_beat_stall_dut%0d", d), 64'(st), 64'd0);
         for (int b = 0; b < 8; b++) begin
            if (be[b]) ref_mem[d][(w + i) % 1024][b*8 +: 8] = beat[i][b*8 +: 8];
         end
         if (gap && i == 0 && n > 1) begin
            wr_s[d] = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      wr_s[d] = 1'b0;
   endtask

   task automatic av_read(input int d, input logic [31:0] a, input logic [7:0] bc, output int stalls);
      int     n;
      int     w;
      bit     ok;
      longint acc;
      exp_t   e;
      n = (bc == 0) ? 1 : int'(bc);
      w = int'((a >> 3) & 32'd1023);
      addr_s[d] = a;
      bc_s[d]   = bc;
      rd_s[d]   = 1'b1;
      handshake(d, ok, acc, stalls);
      rd_s[d]   = 1'b0;
      if (ok) begin
         for (int i = 0; i < n; i++) begin
            e.data = ref_mem[d][(w + i) % 1024];
            e.cyc  = acc + rl(d) + i;
            e.last = (i == n - 1);
            if (d == 0) sb0.push_back(e);
            else sb1.push_back(e);
         end
      end
   endtask

   task automatic mon_step(input int d);
      exp_t e;
      bit   have;
      have = (d == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
      if (have) begin
         if (d == 0) e = sb0[0];
         else e = sb1[0];
      end
      if (rdv_s[d]) begin
         if (!have || e.cyc > cyc) begin
            fail_event($sformatf("unexpected_rdv_dut%0d", d), "readdatavalid=1 with no beat due");
         end else begin
            if (d == 0) void'(sb0.pop_front());
            else void'(sb1.pop_front());
            check($sformatf("rd_cycle_dut%0d", d), 64'(cyc), 64'(e.cyc));
            check($sformatf("rd_data_dut%0d", d), rdata_s[d], e.data);
            if (!e.last) check($sformatf("rpend_wait_dut%0d", d), 64'(wait_s[d]), 64'd1);
         end
      end else if (have && cyc >= e.cyc) begin
         if (d == 0) void'(sb0.pop_front());
         else void'(sb1.pop_front());
         fail_event($sformatf("missing_rdv_dut%0d", d), $sformatf("beat due at cycle %0d never came", e.cyc));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon_step(0);
         mon_step(1);
      end
   end

   initial begin
      int          st;
      bit          seen;
      logic [31:0] a;
      for (int d = 0; d < 2; d++) begin
         addr_s[d] = '0; bc_s[d] = '0; wdata_s[d] = '0; be_s[d] = '0;
         wr_s[d] = 1'b0; rd_s[d] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_wait_dut%0d", d), 64'(wait_s[d]), 64'd1);
         check($sformatf("rst_rdv_dut%0d", d), 64'(rdv_s[d]), 64'd0);
         check($sformatf("rst_rdata_dut%0d", d), rdata_s[d], 64'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("release_wait_dut0", 64'(wait_s[0]), 64'd0);
      check("release_wait_dut1", 64'(wait_s[1]), 64'd1);
      @(posedge clk);
      #1;

      // single write then read
      beat[0] = 64'h1122334455667788;
      av_write(0, 32'h10, 8'd1, 8'hFF, 1'b0, st);
      av_read(0, 32'h10, 8'd1, st);

      // byte enables
      beat[0] = '1;
      av_write(0, 32'h0, 8'd1, 8'hFF, 1'b0, st);
      beat[0] = '0;
      av_write(0, 32'h0, 8'd1, 8'h0F, 1'b0, st);
      av_read(0, 32'h0, 8'd1, st);

      // 4-beat burst with a gap, read back as a burst
      for (int i = 0; i < 4; i++) beat[i] = 64'(i + 1);
      av_write(0, 32'h20, 8'd4, 8'hFF, 1'b1, st);
      av_read(0, 32'h20, 8'd4, st);

      // wrap from the last word to word 0; read word 0 through an aliased address
      beat[0] = 64'hA5A5_0000_0000_1023;
      beat[1] = 64'h5A5A_0000_0000_0000;
      av_write(0, 32'h0000_1FF8, 8'd2, 8'hFF, 1'b0, st);
      av_read(0, 32'h0000_2000, 8'd1, st);

      // simultaneous read and write: write wins, no read data returned
      beat[0] = 64'hDEAD_BEEF_CAFE_F00D;
      rd_s[0] = 1'b1;
      av_write(0, 32'h28, 8'd1, 8'hFF, 1'b0, st);
      rd_s[0] = 1'b0;
      av_read(0, 32'h28, 8'd1, st);

      // byteenable=0 leaves memory unchanged; burstcount 0 acts as 1
      beat[0] = 64'h0123_4567_89AB_CDEF;
      av_write(0, 32'h10, 8'd1, 8'h00, 1'b0, st);
      av_read(0, 32'h10, 8'd1, st);
      beat[0] = 64'hFEED_0000_0000_0001;
      beat[1] = 64'hFEED_0000_0000_0002;
      av_write(0, 32'h30, 8'd0, 8'hFF, 1'b0, st);
      av_read(0, 32'h30, 8'd2, st);

      // fill words 0..63, then random traffic inside that region
      for (int i = 0; i < 64; i++) beat[i] = {$urandom, $urandom};
      av_write(0, 32'h0, 8'd64, 8'hFF, 1'b0, st);
      for (int k = 0; k < 150; k++) begin
         a = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 60)) << 3) | 32'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 4; i++) beat[i] = {$urandom, $urandom};
            av_write(0, a, 8'($urandom_range(0, 4)), 8'($urandom), 1'($urandom_range(0, 1)), st);
         end else begin
            av_read(0, a, 8'($urandom_range(0, 4)), st);
         end
      end

      // wait-state slave: write_word style transfers
      beat[0] = 64'h0BAD_F00D_1234_5678;
      av_write(1, 32'hA0, 8'd1, 8'hFF, 1'b0, st);
      check("ws_write_stalls", 64'(st), 64'(WS1));
      av_read(1, 32'hA0, 8'd1, st);
      check("ws_read_stalls", 64'(st), 64'(WS1));
      beat[0] = 64'h1111_2222_3333_4444;
      beat[1] = 64'h5555_6666_7777_8888;
      av_write(1, 32'hB0, 8'd2, 8'hFF, 1'b0, st);
      check("ws_burst_stalls", 64'(st), 64'(WS1));
      av_read(1, 32'hB0, 8'd2, st);

      // reset in the middle of a 4-beat read, after one beat has returned
      av_read(0, 32'h40, 8'd4, st);
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         seen = rdv_s[0];
      end
      if (!seen) fail_event("midread_first_beat", "no readdatavalid before reset");
      #2;
      rst_n = 1'b0;
      sb0.delete();
      sb1.delete();
      #1;
      check("midread_rst_rdv", 64'(rdv_s[0]), 64'd0);
      check("midread_rst_wait", 64'(wait_s[0]), 64'd1);
      check("midread_rst_rdata", rdata_s[0], 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      av_read(0, 32'h48, 8'd1, st);

      // drain outstanding beats with a bound
      for (int t = 0; t < 200 && (sb0.size() != 0 || sb1.size() != 0); t++) @(posedge clk);
      if (sb0.size() != 0 || sb1.size() != 0) fail_event("drain_timeout", "read beats still outstanding");
      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
